// File: rtl/plc_rx_deframer.sv
// rtl/plc_rx_deframer.sv - PLC serial receive deframer: sync hunt, payload deserializer, output FIFO.
module plc_rx_deframer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    FIFO_DEPTH = 2,
  parameter int                    FRAME_LEN  = 4,
  parameter int                    SYNC_WIDTH = 8,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = 8'hD3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rx_bit,
  input  logic                              rx_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              frame_active,
  output logic                              frame_done,
  output logic                              overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int WW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic {HUNT, PAYLOAD} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_WIDTH-1:0]   sync_q, sync_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]           word_cnt_q, word_cnt_d;
  logic                    frame_done_q, frame_done_d;
  logic                    overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;

  logic [SYNC_WIDTH-1:0]   sync_shift;
  logic [DATA_WIDTH-1:0]   word_shift;
  logic                    push, push_ok, pop;
  logic [CW-1:0]           remaining;

  always_comb begin
    state_d      = state_q;
    sync_d       = sync_q;
    word_d       = word_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    frame_done_d = 1'b0;
    push         = 1'b0;
    sync_shift   = {rx_bit, sync_q[SYNC_WIDTH-1:1]};
    word_shift   = {rx_bit, word_q[DATA_WIDTH-1:1]};

    if (rx_valid) begin
      case (state_q)
        HUNT: begin
          // Register is never cleared on mismatch so overlapping syncs are still found.
          sync_d = sync_shift;
          if (sync_shift == SYNC_WORD) begin
            state_d    = PAYLOAD;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
          end
        end
        default: begin
          word_d = word_shift;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            push      = 1'b1;
            if (word_cnt_q == WORD_LAST) begin
              word_cnt_d   = '0;
              frame_done_d = 1'b1;
              state_d      = HUNT;
              sync_d       = '0;
            end else begin
              word_cnt_d = word_cnt_q + WW'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      endcase
    end

    pop        = (count_q != '0) && out_ready;
    push_ok    = push && ((count_q != CNT_FULL) || pop);
    overflow_d = push && !push_ok;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = word_shift;
      wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Head register: bypass the word being written when it becomes the new head; hold when empty.
    remaining  = count_q - CW'(pop);
    out_data_d = out_data_q;
    if (push_ok && (remaining == '0)) begin
      out_data_d = word_shift;
    end else if (remaining != '0) begin
      out_data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      sync_q       <= '0;
      word_q       <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_data_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      word_q       <= word_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_data_q   <= out_data_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = (count_q != '0);
  assign frame_active = (state_q == PAYLOAD);
  assign frame_done   = frame_done_q;
  assign overflow     = overflow_q;
  assign fifo_count   = count_q;

endmodule

// File: tb/tb_plc_rx_deframer.sv
// tb/tb_plc_rx_deframer.sv - directed self-checking bench for plc_rx_deframer.
module tb_plc_rx_deframer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_bit = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       frame_active;
  logic       frame_done;
  logic       overflow;
  logic [1:0] fifo_count;

  int errors = 0;
  int checks = 0;
  int ovf_cnt = 0;
  int done_cnt = 0;
  logic [7:0] rx_q [$];

  plc_rx_deframer dut (
    .clk(clk), .rst(rst), .rx_bit(rx_bit), .rx_valid(rx_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frame_active(frame_active), .frame_done(frame_done),
    .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Inputs only change at posedge+1, so the negedge view matches what the next edge sees.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) rx_q.push_back(out_data);
      if (overflow) ovf_cnt++;
      if (frame_done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic v);
    rx_bit   = b;
    rx_valid = v;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] w, input bit gappy);
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i], 1'b1);
      if (gappy) send_bit(~w[i], 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
  endtask

  task automatic clear_obs();
    rx_q.delete();
    ovf_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic check_words(input string tag, input int n, input logic [31:0] w0,
                             input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] exp [4];
    exp = '{w0, w1, w2, w3};
    check({tag, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_w%0d", tag, i), (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hFFFF_FFFF, exp[i]);
    end
  endtask

  logic [7:0] t1_words [4];

  initial begin
    t1_words = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_active", frame_active, 0);
    check("rst_done", frame_done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_count", fifo_count, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: basic frame with per-word latency
    clear_obs();
    out_ready = 1'b1;
    send_byte(8'hD3, 0);
    check("t1_active_on", frame_active, 1);
    for (int k = 0; k < 4; k++) begin
      send_byte(t1_words[k], 0);
      check($sformatf("t1_lat_valid%0d", k), out_valid, 1);
      check($sformatf("t1_lat_data%0d", k), out_data, t1_words[k]);
    end
    check("t1_active_off", frame_active, 0);
    idle(3);
    check_words("t1", 4, 'h11, 'h22, 'h33, 'h44);
    check("t1_done", done_cnt, 1);
    check("t1_ovf", ovf_cnt, 0);

    // 2: noise and a broken sync prefix before the real sync
    clear_obs();
    send_byte(8'h5A, 0);
    send_bit(1, 1); send_bit(1, 1); send_bit(0, 1); send_bit(0, 1); send_bit(0, 1);
    check("t2_hunt_active", frame_active, 0);
    check("t2_hunt_words", rx_q.size(), 0);
    send_byte(8'hD3, 0);
    check("t2_active", frame_active, 1);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    idle(3);
    check_words("t2", 4, 'hAA, 'hBB, 'hCC, 'hDD);
    check("t2_done", done_cnt, 1);

    // 3: consumer stalled, two words overflow
    clear_obs();
    out_ready = 1'b0;
    send_byte(8'hD3, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    idle(2);
    check("t3_count", fifo_count, 2);
    check("t3_head", out_data, 8'h01);
    check("t3_ovf", ovf_cnt, 2);
    out_ready = 1'b1;
    idle(4);
    check_words("t3", 2, 'h01, 'h02, 0, 0);
    check("t3_empty", out_valid, 0);
    check("t3_hold", out_data, 8'h02);

    // 4: full FIFO, pop and push on the same edge
    clear_obs();
    out_ready = 1'b0;
    send_byte(8'hD3, 0);
    send_byte(8'h51, 0); send_byte(8'h52, 0);
    check("t4_full", fifo_count, 2);
    for (int i = 0; i < 7; i++) send_bit(((8'h53 >> i) & 1) != 0, 1'b1);
    out_ready = 1'b1;
    send_bit(1'b0, 1'b1);
    out_ready = 1'b0;
    check("t4_count", fifo_count, 2);
    check("t4_ovf_now", overflow, 0);
    check("t4_head", out_data, 8'h52);
    out_ready = 1'b1;
    send_byte(8'h54, 0);
    idle(3);
    check_words("t4", 4, 'h51, 'h52, 'h53, 'h54);
    check("t4_ovf", ovf_cnt, 0);

    // 5: rx_valid toggling every cycle
    clear_obs();
    send_byte(8'hD3, 1);
    repeat (4) send_byte(8'h3C, 1);
    idle(3);
    check_words("t5", 4, 'h3C, 'h3C, 'h3C, 'h3C);
    check("t5_done", done_cnt, 1);

    // 6: async reset mid-frame
    clear_obs();
    out_ready = 1'b0;
    send_byte(8'hD3, 0);
    send_byte(8'h77, 0);
    send_bit(1, 1); send_bit(0, 1); send_bit(1, 1);
    check("t6_pre_count", fifo_count, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_data", out_data, 0);
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_active", frame_active, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_obs();
    out_ready = 1'b1;
    send_byte(8'h9A, 0);
    check("t6_hunt", frame_active, 0);
    send_byte(8'hD3, 0);
    send_byte(8'h9A, 0); send_byte(8'hBC, 0); send_byte(8'hDE, 0); send_byte(8'hF0, 0);
    idle(3);
    check_words("t6", 4, 'h9A, 'hBC, 'hDE, 'hF0);
    check("t6_done", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/plc_rx_deframer.md
Name: plc_rx_deframer

Overview:
Receive-side frame recovery for the PLC bit-serial link. It consumes the descrambled serial bit stream, hunts for a sync word, then deserializes a fixed number of payload words. Recovered words go into an internal FIFO drained through a valid/ready interface. It is the receive counterpart of the transmit FIFO plus serializer path.

Parameters:
DATA_WIDTH, 8, payload word width in bits
FIFO_DEPTH, 2, output FIFO depth in words (>=1)
FRAME_LEN, 4, payload words per frame (>=1)
SYNC_WORD, 8'hD3, sync pattern, SYNC_WIDTH bits wide
SYNC_WIDTH, 8, sync pattern width in bits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
rx_bit  input  1  descrambled serial bit, LSB of each word first
rx_valid  input  1  rx_bit is sampled on this clk edge only when high
out_data  output  DATA_WIDTH  FIFO head word
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts; pop on out_valid && out_ready
frame_active  output  1  high while in PAYLOAD state
frame_done  output  1  one-cycle pulse when the last payload word of a frame completes
overflow  output  1  one-cycle pulse when a completed word is dropped because the FIFO is full
fifo_count  output  $clog2(FIFO_DEPTH+1)  words held

Behaviour:
- Reset (async, active-high): state=HUNT, sync shift register=0, bit/word counters=0, FIFO empty.
- Reset values: out_valid=0, out_data=0, frame_active=0, frame_done=0, overflow=0, fifo_count=0.
- Reset asserted mid-frame discards the partial word, the rest of the frame and the FIFO contents.
- The state machine advances only on edges where rx_valid=1. Gaps in rx_valid hold all bit/word state. FIFO pop still works during gaps.
- HUNT:
  - Sync register shifts right; new bit enters the MSB.
  - Match check uses the register value including the current bit.
  - On match: go to PAYLOAD on the same edge, clear bit and word counters.
  - Overlapping patterns are detected, because the register is not cleared on a mismatch.
- PAYLOAD:
  - Bits assemble LSB first into the word register.
  - On the DATA_WIDTH-th bit, the completed word (including the current bit) is pushed on that same edge.
  - If the FIFO is full with no pop that cycle, the word is dropped and overflow pulses for the next cycle.
  - On the FRAME_LEN-th word: frame_done pulses for the next cycle, state returns to HUNT, and the sync register is cleared to 0. A trailing payload bit can therefore never complete a false sync.
  - Sync patterns inside the payload are ignored.
- frame_active is registered: it goes high the cycle after the sync match and low the cycle after the last payload bit.
- Latency: a pushed word is visible with out_valid=1 on the cycle after the edge sampling its last bit.
- FIFO:
  - Registered circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
  - out_data is the head word; it is held when the FIFO is empty.
  - Simultaneous push and pop:
    - When full: pop frees a slot, the push is accepted, no overflow, count unchanged.
    - When empty: the word is stored and the pop is ignored, since out_valid=0.
  - fifo_count is always in the range 0..FIFO_DEPTH.

Test Plan:
1. Continuous rx_valid=1, out_ready=1; bits of 8'hD3 then 8'h11, 8'h22, 8'h33, 8'h44 (all LSB first) -> out_data sequence 11,22,33,44. Each word appears 1 cycle after its last bit. One frame_done pulse. overflow never set.
2. Noise 8'h5A, then a partial 8'hD3 prefix broken by a bad bit, then a full 8'hD3 and payload 8'hAA, 8'hBB, 8'hCC, 8'hDD -> exactly one sync. Outputs AA,BB,CC,DD. No spurious words during HUNT.
3. out_ready=0, FIFO_DEPTH=2, full frame 01,02,03,04 -> fifo_count=2. Head=01. overflow pulses twice (for words 03 and 04). Raising out_ready then yields 01,02 only.
4. FIFO full (2 words), out_ready=1 on the same edge a new word completes -> pop plus push, fifo_count stays 2, no overflow, order preserved.
5. rx_valid toggled 1/0 every cycle through sync plus payload 8'h3C x4 -> same four words output. Timing stretched; no duplicated or skipped bits.
6. Assert rst after 3 payload bits of word 2 with 1 word in the FIFO -> all outputs zero immediately (async). After release, state is HUNT; a new sync plus frame 9A,BC,DE,F0 is received cleanly.
